// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result normalizer.
// Holds the datapath widths, the packed exponent bias, the packed small-float
// result record and the normalizer FSM state encoding.
package mac_pkg;

   localparam int ACC_W  = 16;
   localparam int FRAC   = 4;
   localparam int PP_W   = 4;
   localparam int OUT_EW = 3;
   localparam int OUT_MW = 2;
   localparam int BIAS   = 2**(OUT_EW-1) - 1;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      NORM,
      OUT
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [OUT_EW-1:0] exp;
      logic [OUT_MW-1:0] mant;
      logic              zero;
      logic              ovf;
   } result_t;

endpackage

// File: rtl/mac_result_normalizer_lead_one_detect.sv
// lead_one_detect: W-wide priority encoder.
// Ports:
//   vec     in   W   value to scan
//   pos     out  PW  bit index of the most significant one (0 when vec == 0)
//   nonzero out  1   vec has at least one bit set
module lead_one_detect #(
   parameter int W  = 16,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [PW-1:0] pos,
   output logic          nonzero
);

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      pos = '0;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) pos = PW'(i);
      end
   end

   assign nonzero = |vec;

endmodule

// File: rtl/mac_result_normalizer.sv
// mac_result_normalizer: aligns a group of per-tile mantissa products to a
// shared exponent, accumulates them in two's complement, then normalises the
// sum and packs it as sign / biased exponent / truncated mantissa.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          product beat handshake
//   in_pp, in_sign             unsigned product and its sign
//   in_emax                    beat exponent
//   in_oe1, in_oe2             per-operand right-shift amounts
//   in_last                    final beat of the group
//   out_valid/out_ready        packed result handshake
//   out_sign, out_exp, out_mant packed small-float result
//   out_zero, out_ovf          zero/flush and saturated-overflow flags
module mac_result_normalizer
   import mac_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PP_W-1:0]   in_pp,
   input  logic              in_sign,
   input  logic [1:0]        in_emax,
   input  logic [1:0]        in_oe1,
   input  logic [1:0]        in_oe2,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [OUT_EW-1:0] out_exp,
   output logic [OUT_MW-1:0] out_mant,
   output logic              out_zero,
   output logic              out_ovf
);

   localparam int PW  = $clog2(ACC_W);
   localparam int E_W = 8;
   localparam logic signed [E_W-1:0] E_MAX = E_W'(2**OUT_EW - 1);

   state_t                  state, state_next;
   logic [ACC_W-1:0]        acc;
   logic [1:0]              grp_e;
   result_t                 res_q, res_d;
   logic                    valid_q;
   logic                    accept;

   logic [2:0]              sh_total;
   logic [PP_W+FRAC-1:0]    pp_frac;
   logic [ACC_W-1:0]        term_base, term_mag, term, acc_align;
   logic [1:0]              e_dn, e_up;

   logic                    s;
   logic [ACC_W-1:0]        mag, mag_sh;
   logic [PW-1:0]           p;
   logic                    nz;
   logic signed [E_W-1:0]   e_norm;

   assign accept = in_valid & in_ready;

   // Beat term: product with guard bits, shifted right by both operand offsets.
   // In ACC a beat with a smaller exponent is additionally aligned down to the
   // group exponent; a beat with a larger exponent instead shifts the
   // accumulator down (acc_align) and becomes the new group exponent.
   assign sh_total  = {1'b0, in_oe1} + {1'b0, in_oe2};
   assign pp_frac   = {in_pp, {FRAC{1'b0}}} >> sh_total;
   assign term_base = {{(ACC_W-PP_W-FRAC){1'b0}}, pp_frac};
   assign e_dn      = grp_e - in_emax;
   assign e_up      = in_emax - grp_e;
   assign term_mag  = (state == ACC && in_emax < grp_e) ? (term_base >> e_dn) : term_base;
   assign term      = in_sign ? (~term_mag + 1'b1) : term_mag;
   assign acc_align = (state == ACC && in_emax > grp_e) ? ACC_W'($signed(acc) >>> e_up) : acc;

   // Normalisation of the finished sum.
   assign s   = acc[ACC_W-1];
   assign mag = s ? (~acc + 1'b1) : acc;

   lead_one_detect #(.W(ACC_W)) u_lod (
      .vec     (mag),
      .pos     (p),
      .nonzero (nz)
   );

   // Shifting the leading one up to the MSB makes the bits below it the
   // mantissa; positions below bit 0 fill with zeros.
   assign mag_sh = mag << (PW'(ACC_W-1) - p);
   assign e_norm = E_W'($signed({{(E_W-2){1'b0}}, grp_e}) +
                        $signed({{(E_W-PW){1'b0}}, p}) + (BIAS - FRAC));

   always_comb begin
      res_d = '0;
      if (!nz) begin
         res_d.zero = 1'b1;
      end else if (e_norm <= 0) begin
         res_d.zero = 1'b1;
         res_d.sign = s;
      end else if (e_norm > E_MAX) begin
         res_d.ovf  = 1'b1;
         res_d.sign = s;
         res_d.exp  = '1;
         res_d.mant = '1;
      end else begin
         res_d.sign = s;
         res_d.exp  = OUT_EW'(e_norm);
         res_d.mant = mag_sh[ACC_W-2 -: OUT_MW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = in_last ? NORM : ACC;
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_next = NORM;
         end
         NORM: state_next = OUT;
         OUT: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         grp_e   <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  grp_e <= in_emax;
                  acc   <= term;
               end
            end
            ACC: begin
               if (accept) begin
                  acc <= acc_align + term;
                  if (in_emax > grp_e) grp_e <= in_emax;
               end
            end
            NORM: begin
               res_q   <= res_d;
               valid_q <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  acc     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = valid_q;
   assign out_sign  = res_q.sign;
   assign out_exp   = res_q.exp;
   assign out_mant  = res_q.mant;
   assign out_zero  = res_q.zero;
   assign out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_mac_result_normalizer.sv
// Directed testbench for mac_result_normalizer. Expected packed results are
// written as {sign, exp[2:0], mant[1:0], zero, ovf}.
module tb_mac_result_normalizer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_pp;
   logic       in_sign;
   logic [1:0] in_emax;
   logic [1:0] in_oe1;
   logic [1:0] in_oe2;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic       out_sign;
   logic [2:0] out_exp;
   logic [1:0] out_mant;
   logic       out_zero;
   logic       out_ovf;
   logic [7:0] res_obs;

   int vectors;
   int miscompares;

   mac_result_normalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pp     (in_pp),
      .in_sign   (in_sign),
      .in_emax   (in_emax),
      .in_oe1    (in_oe1),
      .in_oe2    (in_oe2),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_exp   (out_exp),
      .out_mant  (out_mant),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf)
   );

   assign res_obs = {out_sign, out_exp, out_mant, out_zero, out_ovf};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Present one beat and hold it until the DUT accepts it.
   task automatic apply_stimulus(input logic [3:0] pp, input logic sgn, input logic [1:0] emax,
                                 input logic [1:0] oe1, input logic [1:0] oe2, input logic last);
      int n;
      in_pp    = pp;
      in_sign  = sgn;
      in_emax  = emax;
      in_oe1   = oe1;
      in_oe2   = oe2;
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check_output("beat_accept", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called right after the last beat is accepted: NORM, then OUT, then drain.
   task automatic finish_result(input string tag, input logic [7:0] exp_v);
      check_output({tag, "_norm_valid"}, out_valid, 0);
      check_output({tag, "_norm_ready"}, in_ready, 0);
      step();
      check_output({tag, "_valid"}, out_valid, 1);
      check_output({tag, "_fields"}, res_obs, exp_v);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_output({tag, "_drain"}, out_valid, 0);
      check_output({tag, "_idle_ready"}, in_ready, 1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_pp       = '0;
      in_sign     = 1'b0;
      in_emax     = '0;
      in_oe1      = '0;
      in_oe2      = '0;
      in_last     = 1'b0;
      out_ready   = 1'b0;

      #12;
      check_output("reset_valid", out_valid, 0);
      check_output("reset_fields", res_obs, 8'h00);
      step();
      rst_n = 1'b1;
      step();
      check_output("reset_ready", in_ready, 1);

      // 144 -> p=7, e=7, mant 00
      apply_stimulus(4'd9, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1);
      finish_result("single", 8'b0_111_00_0_0);

      // 64 + 16 = 80 -> e=5, mant 01
      apply_stimulus(4'd4, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
      apply_stimulus(4'd2, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1);
      finish_result("two_beat", 8'b0_101_01_0_0);

      // 64>>>1 + 64 = 96 at emax 1 -> e=6, mant 10
      apply_stimulus(4'd4, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
      apply_stimulus(4'd4, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1);
      finish_result("promote", 8'b0_110_10_0_0);

      // 64 + (64>>2) = 80 at emax 2 -> e=7, mant 01
      apply_stimulus(4'd4, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0);
      apply_stimulus(4'd4, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
      finish_result("demote", 8'b0_111_01_0_0);

      // 96 - 96 = 0
      apply_stimulus(4'd6, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
      apply_stimulus(4'd6, 1'b1, 2'd0, 2'd0, 2'd0, 1'b1);
      finish_result("cancel", 8'b0_000_00_1_0);

      // 144 at emax 3 -> e=9 saturates
      apply_stimulus(4'd9, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1);
      finish_result("ovf", 8'b0_111_11_0_1);

      // 128 at emax 2 -> e=8, first overflowing exponent
      apply_stimulus(4'd8, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1);
      finish_result("ovf_edge", 8'b0_111_11_0_1);

      // -144 -> sign 1, e=7, mant 00
      apply_stimulus(4'd9, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1);
      finish_result("negative", 8'b1_111_00_0_0);

      // 16>>3 = 2, p=1, emax 0 -> e=0 flushes, sign kept
      apply_stimulus(4'd1, 1'b1, 2'd0, 2'd3, 2'd0, 1'b1);
      finish_result("flush", 8'b1_000_00_1_0);

      // 48>>4 = 3, p=1, emax 1 -> e=1, mant {1, missing 0} = 10
      apply_stimulus(4'd3, 1'b0, 2'd1, 2'd2, 2'd2, 1'b1);
      finish_result("min_exp", 8'b0_001_10_0_0);

      // Backpressure: result holds while a new beat waits at the input.
      apply_stimulus(4'd9, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1);
      step();
      in_pp    = 4'd2;
      in_sign  = 1'b0;
      in_emax  = 2'd0;
      in_oe1   = 2'd0;
      in_oe2   = 2'd0;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_output("stall_valid", out_valid, 1);
         check_output("stall_fields", res_obs, 8'b0_111_00_0_0);
         check_output("stall_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_output("stall_drain", out_valid, 0);
      check_output("stall_idle", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      // 32 -> p=5, e=4, mant 00
      finish_result("held_beat", 8'b0_100_00_0_0);

      // Reset in the middle of a group discards the partial sum.
      apply_stimulus(4'd15, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0);
      check_output("acc_ready", in_ready, 1);
      rst_n = 1'b0;
      #1;
      check_output("mid_reset_fields", res_obs, 8'h00);
      check_output("mid_reset_valid", out_valid, 0);
      step();
      rst_n = 1'b1;
      step();
      // 64 at emax 0 -> e=5, mant 00
      apply_stimulus(4'd4, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
      finish_result("after_reset", 8'b0_101_00_0_0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mac_result_normalizer.md
Name: mac_result_normalizer

Overview:
- Consumer end of the reconfigurable 2-bit multiply/exponent tiles in Reconfig_Mac.
- Accepts a stream of per-tile mantissa products, each with its shared exponent and alignment shift amounts.
- Aligns each product, accumulates a group in two's complement, then normalises and packs the sum into a small float (sign/exponent/mantissa).
- Returns the packed result to the low-precision datapath.

Parameters:
- ACC_W, 16: accumulator width (two's complement).
- FRAC, 4: guard fraction bits appended to each product before right-shift.
- OUT_EW, 3: packed exponent width; bias = 2^(OUT_EW-1)-1 = 3.
- OUT_MW, 2: packed mantissa width, hidden leading one excluded.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_pp  in  4  unsigned product M1*M2.
- in_sign  in  1  product sign, 1 = negative.
- in_emax  in  2  beat exponent Emax.
- in_oe1  in  2  right-shift amount, operand 1.
- in_oe2  in  2  right-shift amount, operand 2.
- in_last  in  1  final beat of group.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  result sign.
- out_exp  out  OUT_EW  biased exponent.
- out_mant  out  OUT_MW  mantissa, truncated.
- out_zero  out  1  exact zero / flushed.
- out_ovf  out  1  saturated overflow.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. While low, the FSM goes to IDLE; acc, grp_e and all out_* are cleared to 0; out_valid = 0. Reset mid-group discards the partial sum.
- States: IDLE, ACC, NORM, OUT. in_ready = 1 in IDLE and ACC, 0 otherwise. A beat is accepted on in_valid & in_ready.
- Beat term: term = ({in_pp, FRAC'b0} >> (in_oe1 + in_oe2)), zero-extended to ACC_W and negated if in_sign. Shift range is 0..6; shifted-out bits are truncated.
- IDLE, on accept:
  - grp_e <= in_emax; acc <= term.
  - Go to NORM if in_last, else ACC.
- ACC, on accept:
  - If in_emax < grp_e: term is additionally shifted right by (grp_e - in_emax) before the sign is applied.
  - If in_emax > grp_e: acc is arithmetically shifted right by the difference, grp_e <= in_emax, then term is added.
  - acc <= acc + term, wrapping mod 2^ACC_W with no overflow detection. Go to NORM if in_last.
- NORM (1 cycle):
  - s = acc[MSB]; mag = |acc|; p = index of leading one of mag.
  - e = grp_e + p - FRAC + bias (signed compare).
  - mag == 0: zero=1, exp=0, mant=0, sign=0.
  - e <= 0: flush to zero (zero=1, exp=0, mant=0), sign kept.
  - e > 2^OUT_EW-1: ovf=1, exp all ones, mant all ones.
  - Otherwise: exp = e; mant = mag[p-1 -: OUT_MW], missing low bits read as 0.
  - Outputs registered; go to OUT.
- OUT:
  - out_valid = 1; out_* stable until out_valid & out_ready.
  - On handshake: out_valid <= 0, acc cleared, go to IDLE. A new beat is accepted the cycle after.
- Latency: last beat accepted at cycle T gives out_valid at T+2. Throughput is at most one group per (beats + 2) cycles.
- out_ready is ignored outside OUT. in_valid is ignored while in_ready = 0; the upstream producer holds the beat.

Decomposition:
- Shared package mac_pkg:
  - bias constant.
  - typedef for the packed small-float result struct {sign, exp, mant, zero, ovf}.
  - typedef for the FSM state enum.
- One sub-module, lead_one_detect (ACC_W-wide priority encoder returning p and a nonzero flag), used in NORM.

Test Plan:
- Single beat, pp=9, oe1=oe2=0, emax=1, sign=0, last=1 -> at T+2: sign 0, exp 7, mant 00, zero 0, ovf 0.
- Two beats, (pp=4, oe=0/0, emax=0) then (pp=2, oe1=1, oe2=0, emax=0, last) -> acc 80 -> exp 5, mant 01.
- Exponent promotion, (pp=4, emax=0) then (pp=4, emax=1, last) -> acc 32+64 = 96 -> exp 6, mant 10.
- Cancellation, (pp=6, sign 0) then (pp=6, sign 1, last) -> zero 1, exp 0, mant 0, sign 0.
- Overflow, pp=9, emax=3, last -> ovf 1, exp 7, mant 11.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> out_* stable, in_ready 0.
  - Pulse rst_n low during ACC -> outputs 0 immediately, IDLE; the next group's result is unaffected by the discarded sum.
